// File: rtl/mdu_iterative_if.sv
// Start/busy/done handshake bundle between the execute-stage datapath
// (master) and the iterative multiply/divide unit (slave).
interface mdu_iterative_if #(parameter int n = 32);
  logic         start;
  logic [2:0]   funct3;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         busy;
  logic         done;
  logic [n-1:0] result;

  modport master (output start, funct3, A, B, input busy, done, result);
  modport slave  (input start, funct3, A, B, output busy, done, result);
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RISC-V M-extension unit: shift-add multiplier and restoring
// divider, one bit per cycle, sharing one set of working registers.
// Optional build macro MDU_EARLY_OUT_EN: divide-by-zero and signed-overflow
// requests bypass the bit loop and complete two cycles after acceptance.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide bit per cycle, counter runs down from n
// FIX   | sign correction, special-case override, result write
// DONE  | done pulse; a new start here is accepted back-to-back
module mdu_iterative #(
  parameter int n = 32
) (
  input logic            clk,
  input logic            rst_n,
  mdu_iterative_if.slave bus
);
  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t       state;
  logic [cw-1:0] cnt;
  logic [2:0]   op;
  logic [n-1:0] hi;      // product high half / partial remainder
  logic [n-1:0] lo;      // multiplier, then product low half / dividend, then quotient
  logic [n-1:0] opb;     // multiplicand magnitude / divisor magnitude
  logic [n-1:0] a_raw;   // original A, needed by the special-case results
  logic         sign_a, sign_b, div_zero, div_ovf;
  logic         busy, done;
  logic [n-1:0] result;

  logic         accept, in_div, in_sa, in_sb, in_zero, in_ovf;
  logic [n-1:0] a_mag, b_mag;
  logic [n:0]   mul_sum, shifted, trial;
  logic [2*n-1:0] prod, prod_fix;
  logic [n-1:0] quo_fix, rem_fix, fix_val;

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;

  // Request decode: operand signs, magnitudes and special cases at acceptance.
  always_comb begin
    accept  = bus.start && (state == IDLE || state == DONE);
    in_div  = bus.funct3[2];
    in_sa   = bus.A[n-1] && (in_div ? ~bus.funct3[0]
                                    : (bus.funct3 == 3'b001 || bus.funct3 == 3'b010));
    in_sb   = bus.B[n-1] && (in_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001));
    a_mag   = in_sa ? -bus.A : bus.A;
    b_mag   = in_sb ? -bus.B : bus.B;
    in_zero = in_div && (bus.B == '0);
    in_ovf  = in_div && ~bus.funct3[0] && (bus.A == {1'b1, {(n-1){1'b0}}}) && (bus.B == '1);
  end

  // One iteration step for each datapath; the divider trial is n+1 bits wide.
  always_comb begin
    mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opb : '0)};
    shifted = {hi, lo[n-1]};
    trial   = shifted - {1'b0, opb};
  end

  // Final sign correction, special-case override and result selection.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
    rem_fix  = sign_a ? -hi : hi;
    if (div_zero) begin
      quo_fix = '1;
      rem_fix = a_raw;
    end else if (div_ovf) begin
      quo_fix = a_raw;
      rem_fix = '0;
    end
    fix_val = '0;
    case (op)
      3'b000:                 fix_val = prod_fix[n-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*n-1:n];
      3'b100, 3'b101:         fix_val = quo_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // Control FSM and working registers, with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      a_raw    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op       <= bus.funct3;
            a_raw    <= bus.A;
            sign_a   <= in_sa;
            sign_b   <= in_sb;
            div_zero <= in_zero;
            div_ovf  <= in_ovf;
            hi       <= '0;
            lo       <= in_div ? a_mag : b_mag;
            opb      <= in_div ? b_mag : a_mag;
            cnt      <= cw'(n);
            busy     <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
            state    <= (in_zero || in_ovf) ? FIX : CALC;
`else
            state    <= CALC;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (op[2]) begin
            if (!trial[n]) begin
              hi <= trial[n-1:0];
              lo <= {lo[n-2:0], 1'b1};
            end else begin
              hi <= shifted[n-1:0];
              lo <= {lo[n-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[n:1];
            lo <= {mul_sum[0], lo[n-1:1]};
          end
          cnt <= cnt - cw'(1);
          if (cnt == cw'(1)) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases, back-to-back,
// ignored start, mid-operation reset and randomized ops against a
// plain-arithmetic reference model.
module tb_mdu_iterative;
  localparam int lat_norm = 34;
`ifdef MDU_EARLY_OUT_EN
  localparam int lat_spec = 2;
`else
  localparam int lat_spec = 34;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mdu_iterative_if #(.n(32)) bus ();
  mdu_iterative #(.n(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = ia / ib; return 32'(q);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib; return 32'(q);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present a request for one cycle starting now (at a negedge), then scramble inputs.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.A      = a;
    bus.B      = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.A      = $urandom;
    bus.B      = $urandom;
  endtask

  // Called at the negedge of cycle start_cyc; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int start_cyc, input int lat,
                           input logic [31:0] exp);
    int cyc;
    bit busy_ok;
    cyc     = start_cyc;
    busy_ok = 1'b1;
    while (!bus.done && cyc < 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) busy_ok = 1'b0;
    check_val({tag, " latency"}, 32'(cyc), 32'(lat));
    check_val({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    check_val({tag, " result"}, bus.result, exp);
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check_val({tag, " spurious done"}, {31'b0, seen}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.A      = 32'h0;
    bus.B      = 32'h0;
    repeat (3) @(negedge clk);
    check_val("reset busy", {31'b0, bus.busy}, 32'd0);
    check_val("reset done", {31'b0, bus.done}, 32'd0);
    check_val("reset result", bus.result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{"mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{"mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{"mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{"mulhsu",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{"div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{"rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{"divu",    3'd5, 32'd100,        32'd7,         32'd14});
    vecs.push_back('{"remu",    3'd7, 32'd100,        32'd7,         32'd2});
    vecs.push_back('{"divu0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"remu0",   3'd7, 32'd5,          32'd0,         32'd5});
    vecs.push_back('{"div0",    3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"rem0",    3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});
    vecs.push_back('{"divovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"removf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0});

    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].tag, 1,
                is_special(vecs[i].f3, vecs[i].a, vecs[i].b) ? lat_spec : lat_norm,
                vecs[i].exp);
      @(negedge clk);
      check_val({vecs[i].tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
    end

    // start during CALC is ignored
    issue(3'd5, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.A = 32'd5; bus.B = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored start", 3, lat_norm, 32'd14);
    no_done_for("ignored start", 40);

    // back-to-back: second request in the DONE cycle
    @(negedge clk);
    issue(3'd0, 32'd9, 32'd11);
    wait_done("b2b first", 1, lat_norm, 32'd99);
    issue(3'd7, 32'd100, 32'd7);
    wait_done("b2b second", 1, lat_norm, 32'd2);

    // reset in cycle 10 of a DIV
    @(negedge clk);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("midreset busy", {31'b0, bus.busy}, 32'd0);
    check_val("midreset done", {31'b0, bus.done}, 32'd0);
    check_val("midreset result", bus.result, 32'h0);
    no_done_for("midreset", 40);
    issue(3'd0, 32'd3, 32'd4);
    wait_done("after reset mul", 1, lat_norm, 32'd12);

    // randomized ops, sometimes chained back-to-back
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(f3, a, b);
      wait_done($sformatf("rand%0d f3=%0d", i, f3), 1,
                is_special(f3, a, b) ? lat_spec : lat_norm, ref_mdu(f3, a, b));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
